stopwatch_ctrl: RTL

//  Sequencer for a cascade of decimal digit counters forming a stopwatch.
//  - Divides clk into a timebase tick and runs a START/STOP/CLEAR state machine.
//  - Drives the clock-enable chain of DIGITS BCD counters: digit0 enabled by tick, digit k by carry of k-1.
//  - Sits between the debounced front-panel buttons and the 7-segment display mux.

---
 rtl/stopwatch_ctrl_pkg.sv | 13 +
 rtl/stopwatch_ctrl_digit.sv | 22 ++
 rtl/stopwatch_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared constants for the stopwatch sequencer: FSM encodings, BCD limit and default timebase.
package stopwatch_ctrl_pkg;

    localparam logic [1:0] SW_IDLE  = 2'd0;
    localparam logic [1:0] SW_RUN   = 2'd1;
    localparam logic [1:0] SW_PAUSE = 2'd2;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // 10 ms at 50 MHz
    localparam int TICK_DIV_DEFAULT = 500000;

endpackage

// File: rtl/stopwatch_ctrl_digit.sv
// One decimal digit of the stopwatch cascade: counts 0..9 on ce, carry-out when wrapping.
module bcd_digit_cnt
    import stopwatch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       ce,
    output logic [3:0] q,
    output logic       carry
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 4'd0;
        end else if (ce) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

    assign carry = ce && (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button edge detect, START/STOP/CLEAR FSM, timebase prescaler and BCD cascade.
// Optional lap-hold display freeze is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  running,
    output logic                  overflow,
    output logic                  lap_hold
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [PW-1:0]       presc;
    logic                start_stop_q;
    logic                clear_q;
    logic                start_stop_rise;
    logic                clear_rise;
    logic                zero;
    logic                tick;
    logic [DIGITS:0]     chain;
    logic [4*DIGITS-1:0] live;

    always_ff @(posedge clk) begin
        if (R) begin
            start_stop_q <= 1'b0;
            clear_q      <= 1'b0;
        end else begin
            start_stop_q <= start_stop;
            clear_q      <= clear;
        end
    end

    assign start_stop_rise = start_stop & ~start_stop_q;
    assign clear_rise      = clear & ~clear_q;

    // Anything that lands in IDLE also wipes counters, prescaler phase and overflow.
    assign zero = R | clear_rise;

    always_comb begin
        state_nxt = state;
        if (clear_rise) begin
            state_nxt = SW_IDLE;
        end else if (start_stop_rise) begin
            case (state)
                SW_IDLE:  state_nxt = SW_RUN;
                SW_RUN:   state_nxt = SW_PAUSE;
                SW_PAUSE: state_nxt = SW_RUN;
                default:  state_nxt = SW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state   <= SW_IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == SW_RUN);
        end
    end

    // Prescaler only advances in RUN, so a pause keeps the sub-tick phase.
    always_ff @(posedge clk) begin
        if (zero) begin
            presc <= '0;
        end else if (state == SW_RUN) begin
            presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
        end
    end

    assign tick     = (state == SW_RUN) && (presc == PRESC_MAX);
    assign chain[0] = tick;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cnt u_digit (
            .clk   (clk),
            .clr   (zero),
            .ce    (chain[k]),
            .q     (live[4*k +: 4]),
            .carry (chain[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (zero) begin
            overflow <= 1'b0;
        end else if (chain[DIGITS]) begin
            overflow <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic                lap_q;
    logic                lap_rise;
    logic [4*DIGITS-1:0] lap_latch;

    always_ff @(posedge clk) begin
        if (R) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= lap;
        end
    end

    assign lap_rise = lap & ~lap_q;

    always_ff @(posedge clk) begin
        if (zero) begin
            lap_hold <= 1'b0;
        end else if (lap_rise) begin
            if (lap_hold) begin
                lap_hold <= 1'b0;
            end else if (state == SW_RUN) begin
                lap_hold <= 1'b1;
            end
        end
    end

    // Captures the value shown before this edge's increment.
    always_ff @(posedge clk) begin
        if (lap_rise && !lap_hold && (state == SW_RUN)) begin
            lap_latch <= live;
        end
    end

    assign disp = lap_hold ? lap_latch : live;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_hold   = 1'b0;
    assign disp       = live;
`endif

endmodule
